clk_div_n: RTL and testbench

Programmable integer clock divider generating `clk_out` at f(clk)/N with 50 % duty cycle for both even and odd N. N is loaded at run time and applied glitch-free at period boundaries; start/stop is gated by `en`. It provides divided clocks and period strobes for the slow peripherals and timebases in the design, and replaces fixed even-only dividers.

---
 rtl/clk_div_pkg.sv | 13 +
 rtl/clk_div_half_stage.sv | 26 ++
 rtl/clk_div_n.sv | 120 ++++++++++++
 tb/tb_clk_div_n.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the programmable clock divider.
package clk_div_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        BYPASS = 2'd2
    } state_t;

    localparam int DIV_W_DEFAULT = 8;
    localparam int DIV_DEFAULT   = 6;

endpackage

// File: rtl/clk_div_half_stage.sv
// Negedge half-cycle stage and output select (odd AND, even pass, N=1 bypass mux).
module clk_div_half_stage
    import clk_div_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   p,
    input  logic   odd_sel,
    input  state_t state,
    output logic   clk_out
);

    logic n;

    // p delayed by half a clk; ANDing with p trims the high phase by 0.5 cycle for odd N.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            n <= 1'b0;
        end else begin
            n <= p;
        end
    end

    assign clk_out = (state == BYPASS) ? clk : (odd_sel ? (p & n) : p);

endmodule

// File: rtl/clk_div_n.sv
// Programmable 50 % duty clock divider, f(clk)/N; divisor changes only at period boundaries.
module clk_div_n
    import clk_div_pkg::*;
#(
    parameter int DIV_W       = DIV_W_DEFAULT,
    parameter int DIV_DEFAULT = clk_div_pkg::DIV_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [DIV_W-1:0] div_in,
    input  logic             div_load,
    output logic             clk_out,
    output logic             tick,
    output logic [DIV_W-1:0] div_active
);

    localparam logic [DIV_W-1:0] DIV_RESET = DIV_W'(DIV_DEFAULT);
    localparam logic [DIV_W-1:0] ONE       = DIV_W'(1);
    localparam logic [DIV_W-1:0] TWO       = DIV_W'(2);

    state_t           state, state_nxt;
    logic [DIV_W-1:0] cnt, cnt_inc, cnt_d;
    logic [DIV_W-1:0] pending, pend_eff, active_d;
    logic [DIV_W:0]   half;
    logic             p, p_d, tick_d, odd_sel;
    logic             pend_run, pend_one, boundary;

    // A load on the boundary edge must steer that very edge, so decisions use the forwarded value.
    assign pend_eff = div_load ? div_in : pending;
    assign pend_run = (pend_eff >= TWO);
    assign pend_one = (pend_eff == ONE);
    assign cnt_inc  = (cnt == div_active - ONE) ? '0 : cnt + ONE;
    assign boundary = (state == RUN) && (cnt_inc == '0);
    // One extra bit so N = 2^DIV_W-1 rounds up without wrapping.
    assign half     = ({1'b0, div_active} + (DIV_W+1)'(1)) >> 1;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (en && pend_run) begin
                    state_nxt = RUN;
                end else if (en && pend_one) begin
                    state_nxt = BYPASS;
                end
            end
            RUN: begin
                if (boundary && (!en || !pend_run)) begin
                    state_nxt = IDLE;
                end
            end
            BYPASS: begin
                if (!en || !pend_one) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cnt_d    = '0;
        p_d      = 1'b0;
        tick_d   = 1'b0;
        active_d = div_active;
        if ((state == RUN) && !boundary) begin
            cnt_d = cnt_inc;
            p_d   = ({1'b0, cnt_inc} < half);
        end else if (state_nxt == RUN) begin
            active_d = pend_eff;
            p_d      = 1'b1;
            tick_d   = 1'b1;
        end else if (state_nxt == BYPASS) begin
            active_d = pend_eff;
            tick_d   = 1'b1;
        end
        if (boundary) begin
            active_d = pend_eff;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt        <= '0;
            p          <= 1'b0;
            tick       <= 1'b0;
            pending    <= DIV_RESET;
            div_active <= DIV_RESET;
            odd_sel    <= DIV_RESET[0];
        end else begin
            cnt        <= cnt_d;
            p          <= p_d;
            tick       <= tick_d;
            pending    <= pend_eff;
            div_active <= active_d;
            odd_sel    <= active_d[0];
        end
    end

    clk_div_half_stage u_half_stage (
        .clk     (clk),
        .reset   (reset),
        .p       (p),
        .odd_sel (odd_sel),
        .state   (state),
        .clk_out (clk_out)
    );

endmodule

// File: tb/tb_clk_div_n.sv
// Scoreboarded bench for clk_div_n: a period-level model queues expected periods, a monitor checks ticks and half-cycle levels.
module tb_clk_div_n;

    localparam int DIV_W = 8;
    localparam int T     = 10;

    logic             clk, reset, en, div_load;
    logic [DIV_W-1:0] div_in, div_active;
    logic             clk_out, tick;

    clk_div_n #(.DIV_W(DIV_W), .DIV_DEFAULT(6)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .div_in     (div_in),
        .div_load   (div_load),
        .clk_out    (clk_out),
        .tick       (tick),
        .div_active (div_active)
    );

    initial clk = 1'b0;
    always #(T/2) clk = ~clk;

    typedef struct { int n; time t; } exp_t;
    typedef enum { M_IDLE, M_RUN, M_BYP } mode_t;

    exp_t  exp_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    mode_t m_mode = M_IDLE;
    int    m_pend = 6;
    int    m_active = 6;
    time   m_end = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Each period of N lasts N clk cycles from the edge that starts it.
    task automatic start_period(input int n);
        m_active = n;
        m_end    = $time + time'(n * T);
        exp_q.push_back('{n, $time});
    endtask

    task automatic model_step(input bit e, input bit ld, input int d);
        int pe;
        pe = ld ? d : m_pend;
        case (m_mode)
            M_IDLE: begin
                if (e && pe >= 2) begin
                    start_period(pe);
                    m_mode = M_RUN;
                end else if (e && pe == 1) begin
                    m_active = 1;
                    m_mode   = M_BYP;
                    exp_q.push_back('{1, $time});
                end
            end
            M_RUN: begin
                if ($time == m_end) begin
                    m_active = pe;
                    if (e && pe >= 2) start_period(pe);
                    else m_mode = M_IDLE;
                end
            end
            M_BYP: begin
                if (!e || pe != 1) m_mode = M_IDLE;
                else exp_q.push_back('{1, $time});
            end
            default: m_mode = M_IDLE;
        endcase
        m_pend = pe;
    endtask

    task automatic cycle(input bit e, input bit ld, input int d);
        @(negedge clk);
        en       = e;
        div_load = ld;
        div_in   = DIV_W'(d);
        @(posedge clk);
        if (reset) model_step(e, ld, d);
    endtask

    task automatic wait_tick(input int bound);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            cycle(1'b1, 1'b0, 0);
            #1;
            seen = tick;
        end
        check("tick_wait", longint'(seen), 1);
    endtask

    // Period of N is 2N half-cycles; high for N halves, shifted by one half for odd N >= 3.
    task automatic check_level(input int n, input int h);
        int  off;
        bit  exp_lvl;
        off     = (n >= 3 && (n % 2) == 1) ? 1 : 0;
        exp_lvl = (n > 0) && (h < 2 * n) && (h >= off) && (h < off + n);
        check("clk_out_level", longint'(clk_out), longint'(exp_lvl));
    endtask

    initial begin
        int   h;
        int   cur_n;
        exp_t it;
        h     = 0;
        cur_n = 0;
        forever begin
            @(posedge clk);
            #2;
            if (!reset) begin
                cur_n = 0;
            end else begin
                if (tick) begin
                    if (exp_q.size() == 0) begin
                        check("tick_unexpected", longint'(tick), 0);
                        h++;
                    end else begin
                        it = exp_q.pop_front();
                        check("tick_time", longint'($time - 2), longint'(it.t));
                        check("div_active_at_tick", longint'(div_active), it.n);
                        cur_n = it.n;
                        h     = 0;
                    end
                end else begin
                    h++;
                end
                check_level(cur_n, h);
            end
            #5;
            if (reset) begin
                h++;
                check_level(cur_n, h);
            end
        end
    end

    initial begin
        bit seen;
        reset    = 1'b0;
        en       = 1'b0;
        div_load = 1'b0;
        div_in   = '0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_clk_out", longint'(clk_out), 0);
        check("reset_tick", longint'(tick), 0);
        check("reset_div_active", longint'(div_active), 6);
        #2 reset = 1'b1;

        // Default N=6, then N=5 loaded mid-period.
        repeat (20) cycle(1'b1, 1'b0, 0);
        cycle(1'b1, 1'b1, 5);
        repeat (20) cycle(1'b1, 1'b0, 0);

        // N=4 loaded in the high phase of an N=7 period.
        cycle(1'b1, 1'b1, 7);
        wait_tick(20);
        cycle(1'b1, 1'b0, 0);
        cycle(1'b1, 1'b1, 4);
        repeat (25) cycle(1'b1, 1'b0, 0);

        // N=8 stopped mid-period, then N=0 (stopped) and N=1 (bypass).
        cycle(1'b1, 1'b1, 8);
        wait_tick(20);
        repeat (3) cycle(1'b1, 1'b0, 0);
        repeat (15) cycle(1'b0, 1'b0, 0);
        check("div_active_after_stop", longint'(div_active), m_active);
        cycle(1'b0, 1'b1, 0);
        repeat (10) cycle(1'b1, 1'b0, 0);
        cycle(1'b1, 1'b1, 1);
        repeat (10) cycle(1'b1, 1'b0, 0);
        cycle(1'b0, 1'b0, 0);

        // Randomized enables and loads.
        for (int i = 0; i < 400; i++) begin
            bit e, ld;
            int d;
            e  = ($urandom_range(0, 9) != 0);
            ld = ($urandom_range(0, 19) == 0);
            d  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 12));
            cycle(e, ld, d);
        end

        // Largest divisor.
        cycle(1'b1, 1'b1, 255);
        repeat (900) cycle(1'b1, 1'b0, 0);

        // Asynchronous reset in the middle of a high phase.
        seen = 1'b0;
        for (int i = 0; i < 600 && !seen; i++) begin
            cycle(1'b1, 1'b0, 0);
            #2;
            seen = clk_out;
        end
        check("high_phase_found", longint'(seen), 1);
        @(negedge clk);
        en       = 1'b0;
        div_load = 1'b0;
        #3 reset = 1'b0;
        #1;
        check("async_reset_clk_out", longint'(clk_out), 0);
        check("async_reset_tick", longint'(tick), 0);
        exp_q.delete();
        m_mode   = M_IDLE;
        m_pend   = 6;
        m_active = 6;
        repeat (2) @(negedge clk);
        #3 reset = 1'b1;
        #1;
        check("post_reset_div_active", longint'(div_active), m_active);
        check("post_reset_clk_out", longint'(clk_out), 0);

        repeat (20) cycle(1'b1, 1'b0, 0);
        repeat (12) cycle(1'b0, 1'b0, 0);
        #3;
        check("queue_drained", longint'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
